// File: rtl/threefish_iter_engine_if.sv
// threefish_iter_engine_if: valid/ready bundle carrying key/tweak/plaintext in
// and ciphertext out of the Threefish engine.
interface threefish_iter_engine_if #(
    parameter int NW = 8
);
    logic             inValid;
    logic             outReady;
    logic [NW*64-1:0] inKey;
    logic [127:0]     inTweak;
    logic [NW*64-1:0] inBlock;
    logic             outValid;
    logic             inReady;
    logic [NW*64-1:0] outBlock;
    modport slave (
        input  inValid, inKey, inTweak, inBlock, inReady,
        output outReady, outValid, outBlock
    );
    modport master (
        output inValid, inKey, inTweak, inBlock, inReady,
        input  outReady, outValid, outBlock
    );
endinterface

// File: rtl/threefish_iter_engine.sv
// threefish_iter_engine: iterative Threefish-256/512 encryptor running RPC rounds per
// clock, with the key schedule derived on the fly from latched key and tweak words.
module threefish_iter_engine #(
    parameter int NW  = 8,
    parameter int RPC = 4,
    parameter int NR  = 72
) (
    input logic                    inClk,
    input logic                    inRstN,
    threefish_iter_engine_if.slave bus
);
    typedef logic [NW-1:0][63:0] blk_t;
    typedef logic [NW:0][63:0]   key_t;
    typedef logic [2:0][63:0]    twk_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;
    // Tables are padded to a common 8x4 shape so one lookup serves both widths
    localparam int R4 [8][4] = '{'{14, 16, 0, 0}, '{52, 57, 0, 0}, '{23, 40, 0, 0}, '{5, 37, 0, 0},
                                 '{25, 33, 0, 0}, '{46, 12, 0, 0}, '{58, 22, 0, 0}, '{32, 32, 0, 0}};
    localparam int R8 [8][4] = '{'{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44, 9, 54, 56},
                                 '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{8, 35, 56, 22}};
    localparam int P4 [8] = '{0, 3, 2, 1, 0, 0, 0, 0};
    localparam int P8 [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
    if (!(NW == 4 || NW == 8) || !(RPC == 1 || RPC == 2 || RPC == 4) || NR != 72) begin : g_illegal
        $error("threefish_iter_engine: unsupported NW/RPC/NR");
    end
    state_t     state_q, state_d;
    key_t       k_q, k_d, kin;
    twk_t       t_q, t_d, tin;
    blk_t       v_q, v_d, out_q, out_d, x, f;
    logic [6:0] d_q, d_d, dn;
    function automatic logic [63:0] rotl(input logic [63:0] w, input int n);
        return (w << n) | (w >> (64 - n));
    endfunction
    function automatic blk_t add(input blk_t a, input blk_t b);
        for (int i = 0; i < NW; i++) a[i] = a[i] + b[i];
        return a;
    endfunction
    function automatic blk_t subkey(input key_t k, input twk_t t, input int s);
        blk_t sk;
        for (int i = 0; i < NW; i++) sk[i] = k[(s + i) % (NW + 1)];
        sk[NW-3] = sk[NW-3] + t[s % 3];
        sk[NW-2] = sk[NW-2] + t[(s + 1) % 3];
        sk[NW-1] = sk[NW-1] + 64'(s);
        return sk;
    endfunction
    always_comb begin
        kin = {C240, bus.inKey};
        for (int i = 0; i < NW; i++) kin[NW] = kin[NW] ^ bus.inKey[64*i +: 64];
        tin = {bus.inTweak[63:0] ^ bus.inTweak[127:64], bus.inTweak};
        x = v_q;
        f = v_q;
        for (int r = 0; r < RPC; r++) begin
            for (int i = 0; i < NW / 2; i++) begin
                f[2*i]   = x[2*i] + x[2*i+1];
                f[2*i+1] = rotl(x[2*i+1], NW == 4 ? R4[(int'(d_q) + r) % 8][i]
                                                  : R8[(int'(d_q) + r) % 8][i]) ^ f[2*i];
            end
            for (int i = 0; i < NW; i++) x[i] = f[(NW == 4 ? P4[i] : P8[i]) % NW];
        end
        dn = d_q + 7'(RPC);
        x = dn[1:0] == 2'b00 ? add(x, subkey(k_q, t_q, int'(dn[6:2]))) : x;
        state_d = state_q;
        k_d = k_q;
        t_d = t_q;
        v_d = v_q;
        d_d = d_q;
        out_d = out_q;
        if (state_q == IDLE && bus.inValid) begin
            state_d = RUN;
            k_d = kin;
            t_d = tin;
            v_d = add(bus.inBlock, subkey(kin, tin, 0));
            d_d = '0;
        end
        if (state_q == RUN) begin
            state_d = dn == 7'(NR) ? DONE : RUN;
            v_d = x;
            d_d = dn;
            out_d = dn == 7'(NR) ? x : out_q;
        end
        if (state_q == DONE && bus.inReady) state_d = IDLE;
    end
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= IDLE;
            k_q <= '0;
            t_q <= '0;
            v_q <= '0;
            d_q <= '0;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            t_q <= t_d;
            v_q <= v_d;
            d_q <= d_d;
            out_q <= out_d;
        end
    end
    assign bus.outReady = state_q == IDLE;
    assign bus.outValid = state_q == DONE;
    assign bus.outBlock = out_q;
endmodule

// File: tb/tb_threefish_iter_engine.sv
// tb_threefish_iter_engine: four engine configurations driven from a shared vector
// table and checked against a word-array Threefish reference model.
module tb_threefish_iter_engine;
    logic clk, rst_n;
    logic iv [4];
    logic ir [4];
    logic ov [4];
    logic orr [4];
    logic [511:0] ob [4];
    logic [511:0] key_s, blk_s;
    logic [127:0] tw_s;
    int checks = 0;
    int errors = 0;
    localparam int LAT [4] = '{18, 36, 72, 72};
    localparam int RT4 [8][2] = '{'{14, 16}, '{52, 57}, '{23, 40}, '{5, 37},
                                  '{25, 33}, '{46, 12}, '{58, 22}, '{32, 32}};
    localparam int RT8 [8][4] = '{'{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44, 9, 54, 56},
                                  '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{8, 35, 56, 22}};
    localparam int PM4 [4] = '{0, 3, 2, 1};
    localparam int PM8 [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
    threefish_iter_engine_if #(.NW(8)) b84 ();
    threefish_iter_engine_if #(.NW(8)) b82 ();
    threefish_iter_engine_if #(.NW(8)) b81 ();
    threefish_iter_engine_if #(.NW(4)) b41 ();
    threefish_iter_engine #(.NW(8), .RPC(4)) u84 (.inClk(clk), .inRstN(rst_n), .bus(b84));
    threefish_iter_engine #(.NW(8), .RPC(2)) u82 (.inClk(clk), .inRstN(rst_n), .bus(b82));
    threefish_iter_engine #(.NW(8), .RPC(1)) u81 (.inClk(clk), .inRstN(rst_n), .bus(b81));
    threefish_iter_engine #(.NW(4), .RPC(1)) u41 (.inClk(clk), .inRstN(rst_n), .bus(b41));
    assign b84.inValid = iv[0];
    assign b82.inValid = iv[1];
    assign b81.inValid = iv[2];
    assign b41.inValid = iv[3];
    assign b84.inReady = ir[0];
    assign b82.inReady = ir[1];
    assign b81.inReady = ir[2];
    assign b41.inReady = ir[3];
    assign b84.inKey = key_s;
    assign b82.inKey = key_s;
    assign b81.inKey = key_s;
    assign b41.inKey = key_s[255:0];
    assign b84.inBlock = blk_s;
    assign b82.inBlock = blk_s;
    assign b81.inBlock = blk_s;
    assign b41.inBlock = blk_s[255:0];
    assign b84.inTweak = tw_s;
    assign b82.inTweak = tw_s;
    assign b81.inTweak = tw_s;
    assign b41.inTweak = tw_s;
    assign ov[0] = b84.outValid;
    assign ov[1] = b82.outValid;
    assign ov[2] = b81.outValid;
    assign ov[3] = b41.outValid;
    assign orr[0] = b84.outReady;
    assign orr[1] = b82.outReady;
    assign orr[2] = b81.outReady;
    assign orr[3] = b41.outReady;
    assign ob[0] = b84.outBlock;
    assign ob[1] = b82.outBlock;
    assign ob[2] = b81.outBlock;
    assign ob[3] = {256'b0, b41.outBlock};
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction
    // Reference Threefish: 19 subkey injections with four rounds between each.
    function automatic logic [511:0] tf_ref(input int nw, input logic [511:0] key,
                                            input logic [127:0] tw, input logic [511:0] pt);
        logic [63:0] k [9];
        logic [63:0] t [3];
        logic [63:0] v [8];
        logic [63:0] f [8];
        logic [63:0] a;
        logic [511:0] ct;
        int r;
        k[nw] = 64'h1BD11BDAA9FC1A22;
        for (int i = 0; i < nw; i++) begin
            k[i] = key[64*i +: 64];
            k[nw] = k[nw] ^ k[i];
            v[i] = pt[64*i +: 64];
        end
        t[0] = tw[63:0];
        t[1] = tw[127:64];
        t[2] = t[0] ^ t[1];
        for (int s = 0; s <= 18; s++) begin
            for (int i = 0; i < nw; i++) begin
                a = k[(s + i) % (nw + 1)];
                if (i == nw - 3) a = a + t[s % 3];
                if (i == nw - 2) a = a + t[(s + 1) % 3];
                if (i == nw - 1) a = a + 64'(s);
                v[i] = v[i] + a;
            end
            for (int d = 4 * s; d < 4 * s + 4 && s < 18; d++) begin
                for (int i = 0; i < nw / 2; i++) begin
                    r = (nw == 4) ? RT4[d % 8][i] : RT8[d % 8][i];
                    f[2*i] = v[2*i] + v[2*i+1];
                    f[2*i+1] = ((v[2*i+1] << r) | (v[2*i+1] >> (64 - r))) ^ f[2*i];
                end
                for (int i = 0; i < nw; i++) v[i] = f[(nw == 4) ? PM4[i] : PM8[i]];
            end
        end
        ct = '0;
        for (int i = 0; i < nw; i++) ct[64*i +: 64] = v[i];
        return ct;
    endfunction
    logic [511:0] last_ct [4];
    task automatic run_job(input logic [511:0] key, input logic [127:0] tw, input logic [511:0] pt,
                           input logic [511:0] e8, input logic [511:0] e4, input logic [3:0] m);
        int lat [4];
        bit held [4];
        int pend;
        logic [511:0] scr;
        key_s = key;
        tw_s = tw;
        blk_s = pt;
        pend = 0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = m[i];
            lat[i] = -1;
            held[i] = 1'b1;
            pend += int'(m[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            if (m[i]) chk($sformatf("accept%0d", i), 512'(orr[i]), 512'(0));
        end
        scr = rnd512();
        key_s = scr;
        blk_s = ~scr;
        tw_s = scr[255:128];
        for (int c = 1; c <= 100 && pend > 0; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (m[i] && lat[i] < 0 && ov[i]) begin
                    lat[i] = c;
                    last_ct[i] = ob[i];
                    pend--;
                end else if (m[i] && lat[i] >= 0 && (!ov[i] || ob[i] !== last_ct[i])) begin
                    held[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                chk($sformatf("latency%0d", i), 512'(lat[i]), 512'(LAT[i]));
                chk($sformatf("ct%0d", i), last_ct[i], i == 3 ? e4 : e8);
                chk($sformatf("done_hold%0d", i), 512'(held[i]), 512'(1));
            end
            ir[i] = m[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            ir[i] = 1'b0;
            if (m[i]) chk($sformatf("release%0d", i), 512'({ov[i], orr[i]}), 512'(2'b01));
        end
    endtask
    typedef struct {
        logic [511:0] key;
        logic [127:0] tw;
        logic [511:0] pt;
        logic [511:0] e8;
        logic [511:0] e4;
    } vec_t;
    vec_t vt [6];
    initial begin
        logic [511:0] k1, p1, e1, k2, p2, e2, tmp;
        logic [127:0] t1, t2;
        int lat;
        bit stray;
        rst_n = 1'b0;
        key_s = '0;
        blk_s = '0;
        tw_s = '0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ir[i] = 1'b0;
        end
        vt[0].key = '0;
        vt[0].tw = '0;
        vt[0].pt = '0;
        for (int i = 0; i < 64; i++) begin
            vt[1].key[8*i +: 8] = 8'(16 + i);
            vt[1].pt[8*i +: 8] = 8'(255 - i);
        end
        for (int i = 0; i < 16; i++) vt[1].tw[8*i +: 8] = 8'(i);
        for (int n = 2; n < 6; n++) begin
            vt[n].key = rnd512();
            vt[n].pt = rnd512();
            tmp = rnd512();
            vt[n].tw = tmp[127:0];
        end
        for (int n = 0; n < 6; n++) begin
            vt[n].e8 = tf_ref(8, vt[n].key, vt[n].tw, vt[n].pt);
            vt[n].e4 = tf_ref(4, vt[n].key, vt[n].tw, vt[n].pt);
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ctl%0d", i), 512'({ov[i], orr[i]}), 512'(2'b01));
            chk($sformatf("rst_ob%0d", i), ob[i], '0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            run_job(vt[n].key, vt[n].tw, vt[n].pt, vt[n].e8, vt[n].e4, 4'b1111);
            if (n == 0) chk("kat256_w0", 512'(last_ct[3][63:0]), 512'(64'h94EEEA8B1F2ADA84));
        end
        // Back-pressure in DONE, then a second block offered on the release cycle
        k1 = rnd512();
        p1 = rnd512();
        tmp = rnd512();
        t1 = tmp[127:0];
        e1 = tf_ref(8, k1, t1, p1);
        key_s = k1;
        blk_s = p1;
        tw_s = t1;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (ov[0]) lat = c;
        end
        chk("bp_latency", 512'(lat), 512'(18));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_ctl", 512'({ov[0], orr[0]}), 512'(2'b10));
            chk("bp_ob", ob[0], e1);
        end
        k2 = rnd512();
        p2 = rnd512();
        tmp = rnd512();
        t2 = tmp[127:0];
        e2 = tf_ref(8, k2, t2, p2);
        key_s = k2;
        blk_s = p2;
        tw_s = t2;
        iv[0] = 1'b1;
        ir[0] = 1'b1;
        @(posedge clk);
        #1;
        ir[0] = 1'b0;
        chk("bp_idle", 512'({ov[0], orr[0]}), 512'(2'b01));
        chk("bp_keep_ob", ob[0], e1);
        @(posedge clk);
        #1;
        chk("bp_accept", 512'(orr[0]), 512'(0));
        key_s = rnd512();
        blk_s = rnd512();
        lat = -1;
        stray = 1'b0;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            iv[0] = ~iv[0];
            @(posedge clk);
            #1;
            if (ov[0]) lat = c;
            else if (orr[0]) stray = 1'b1;
        end
        iv[0] = 1'b0;
        chk("tog_no_accept", 512'(stray), 512'(0));
        chk("tog_latency", 512'(lat), 512'(18));
        chk("tog_ct", ob[0], e2);
        ir[0] = 1'b1;
        @(posedge clk);
        #1;
        ir[0] = 1'b0;
        // Abort at round 20 with an asynchronous reset
        key_s = rnd512();
        blk_s = rnd512();
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort_ctl%0d", i), 512'({ov[i], orr[i]}), 512'(2'b01));
            chk($sformatf("abort_ob%0d", i), ob[i], '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_job(vt[0].key, vt[0].tw, vt[0].pt, vt[0].e8, vt[0].e4, 4'b1111);
        chk("post_rst_kat256_w0", 512'(last_ct[3][63:0]), 512'(64'h94EEEA8B1F2ADA84));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
